uart_tx: RTL

- UART transmitter: 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Bytes from the host-side CPU/terminal logic are queued in a small internal FIFO and serialised at CLKS_PER_BIT clocks per bit.
- Companion to the UART receiver: same bit timing and framing, drives the board's serial TX pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - uart_state_e : frame state machine encoding (IDLE, START, DATA, STOP)
//   - CLKS_PER_BIT_DEFAULT : default bit period in system clocks
//   - DATA_BITS / FRAME_BITS : 8N1 frame geometry
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 217;
  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS           = DATA_BITS + 2;  // start + data + stop

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO_DEPTH x 8 byte queue for the UART transmitter.
// Ports:
//   i_Clock, i_Reset : clock, synchronous active-high reset (empties the queue)
//   push, push_data  : enqueue request; ignored when the queue is full
//   pop, head        : dequeue request; head is the oldest byte (valid when !empty)
//   full, empty      : flags derived from count after each edge
//   count            : number of bytes held, 0..FIFO_DEPTH
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  input  logic                          pop,
  output logic [7:0]                    head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Room is judged on the count before the edge, so a pop in the same cycle
  // never makes space for a write to a full queue.
  assign do_push = push && (count != DEPTH_CNT);
  assign do_pop  = pop && (count != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap by plain overflow.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;  // idle or simultaneous push+pop: count unchanged
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only read
  // after being written, and leaving it out of reset lets it map onto RAM.
  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: queued 8N1 UART transmitter (start bit, 8 data bits LSB first,
// stop bit), CLKS_PER_BIT clocks per bit, back-to-back frames without gaps.
// Ports:
//   i_Clock       : system clock, rising edge
//   i_Reset       : synchronous active-high reset; aborts any frame in flight
//   i_Tx_DV       : write strobe, byte queued when the FIFO is not full
//   i_Tx_Byte     : byte to transmit
//   o_Tx_Serial   : registered serial line, idle high
//   o_Tx_Active   : high while the state machine is in START/DATA/STOP
//   o_Tx_Done     : one-cycle pulse on the last cycle of each stop bit
//   o_Tx_Full     : queue holds FIFO_DEPTH bytes
//   o_Tx_Empty    : queue holds no bytes
//   o_Tx_Overflow : one-cycle pulse after a write attempted while full (byte dropped)
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic       o_Tx_Full,
  output logic       o_Tx_Empty,
  output logic       o_Tx_Overflow
);

  localparam int CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int BIT_W      = $clog2(DATA_BITS);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]      BIT_LAST     = BIT_W'(DATA_BITS - 1);
  localparam logic [FIFO_CNT_W-1:0] FIFO_CNT_MAX = FIFO_CNT_W'(FIFO_DEPTH);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  serial_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [7:0]            fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;

  assign fifo_push = i_Tx_DV && (fifo_count < FIFO_CNT_MAX);

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .push      (fifo_push),
    .push_data (i_Tx_Byte),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state logic. The STOP state pops the next byte itself so that
  // queued frames follow each other without an idle bit between them.
  always_comb begin
    // NOTE: every variable gets a default before the case; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = START;
        end
      end

      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Line level for the current state; registered below, so the pin trails
  // the state by one clock and every bit still lasts CLKS_PER_BIT cycles.
  always_comb begin
    serial_d = 1'b1;
    case (state_q)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_q[bit_q];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      o_Tx_Serial   <= 1'b1;
      o_Tx_Overflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      o_Tx_Serial   <= serial_d;
      o_Tx_Overflow <= i_Tx_DV && fifo_full;
    end
  end

  assign o_Tx_Active = (state_q != IDLE);
  assign o_Tx_Done   = (state_q == STOP) && (cnt_q == CNT_LAST);
  assign o_Tx_Full   = fifo_full;
  assign o_Tx_Empty  = fifo_empty;

endmodule
